// File: rtl/nibble_serial_subtractor_16_bit.sv
// 16-bit subtractor that works one 4-bit slice per cycle, LSB slice first.
// Valid/ready handshake on both sides; the result is held until consumed.
module nibble_serial_subtractor_16_bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        bin,
  output logic [15:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_k;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_borrow;
  logic [15:0] r_acc;
  logic [15:0] r_diff;
  logic        r_bout;
  logic        r_ovf;

  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic [4:0]  w_slice;
  logic        w_borrow_nxt;
  logic [15:0] w_acc_nxt;
  logic        w_ovf_nxt;

  // Select the current slice, subtract it, and splice it into the accumulator.
  always_comb begin
    w_a_nib   = 4'd0;
    w_b_nib   = 4'd0;
    w_acc_nxt = r_acc;
    unique case (r_k)
      2'd0: begin
        w_a_nib = r_a[3:0];
        w_b_nib = r_b[3:0];
      end
      2'd1: begin
        w_a_nib = r_a[7:4];
        w_b_nib = r_b[7:4];
      end
      2'd2: begin
        w_a_nib = r_a[11:8];
        w_b_nib = r_b[11:8];
      end
      2'd3: begin
        w_a_nib = r_a[15:12];
        w_b_nib = r_b[15:12];
      end
    endcase
    w_slice = {1'b0, w_a_nib} - {1'b0, w_b_nib} - {4'd0, r_borrow};
    w_borrow_nxt = w_slice[4];
    unique case (r_k)
      2'd0: w_acc_nxt[3:0]   = w_slice[3:0];
      2'd1: w_acc_nxt[7:4]   = w_slice[3:0];
      2'd2: w_acc_nxt[11:8]  = w_slice[3:0];
      2'd3: w_acc_nxt[15:12] = w_slice[3:0];
    endcase
    w_ovf_nxt = (r_a[15] != r_b[15]) && (w_acc_nxt[15] != r_a[15]);
  end

  // Handshake FSM, slice datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_k      <= 2'd0;
      r_a      <= 16'd0;
      r_b      <= 16'd0;
      r_borrow <= 1'b0;
      r_acc    <= 16'd0;
      r_diff   <= 16'd0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_k      <= 2'd0;
            r_acc    <= 16'd0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_nxt;
          r_borrow <= w_borrow_nxt;
          r_k      <= r_k + 2'd1;
          if (r_k == 2'd3) begin
            r_diff  <= w_acc_nxt;
            r_bout  <= w_borrow_nxt;
            r_ovf   <= w_ovf_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule
